mod7_counter: RTL and testbench

- Synchronous up/down counter modulo 7. Output sequence is 0..6 with wrap-around in both directions.
- Counts one step per clock when enabled (`now`). Direction is selected by `dir`.
- Leaf block used as a small cyclic index/phase generator. No internal hierarchy.

---
 rtl/mod7_counter.sv | 73 +++++++
 tb/tb_mod7_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mod7_counter.sv
// mod7_counter: modulo-MODULUS up/down counter with a registered output.
// Define MOD7_WRAP_FLAG_EN to add a registered one-cycle wrap pulse.
module mod7_counter #(
  parameter int unsigned MODULUS = 7,
  parameter int unsigned WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             now,
`ifdef MOD7_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] value
);

  // Range compare is done one bit wider so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > 8 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("mod7_counter: illegal MODULUS/WIDTH combination");
  end

  logic             legal;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] value_nxt;

  always_comb begin
    legal     = ({1'b0, value} < MOD_EXT);
    at_top    = (value == TOP);
    at_zero   = (value == '0);
    value_nxt = value;
    if (!legal) begin
      value_nxt = '0;
    end else if (now) begin
      if (dir) begin
        value_nxt = at_top ? '0 : value + WIDTH'(1);
      end else begin
        value_nxt = at_zero ? TOP : value - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

`ifdef MOD7_WRAP_FLAG_EN
  logic wrap_nxt;

  always_comb begin
    wrap_nxt = 1'b0;
    if (legal && now) begin
      wrap_nxt = dir ? at_top : at_zero;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mod7_counter.sv
// Self-checking bench for mod7_counter: vector table, hand-written corner
// sequences and a randomized run against a modulo model, via a scoreboard queue.
module tb_mod7_counter;

  logic       clk;
  logic       rst;
  logic       dir;
  logic       now;
  logic [2:0] value;
`ifdef MOD7_WRAP_FLAG_EN
  logic       wrap;
`endif

  mod7_counter #(
    .MODULUS(7),
    .WIDTH  (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .dir  (dir),
    .now  (now),
`ifdef MOD7_WRAP_FLAG_EN
    .wrap (wrap),
`endif
    .value(value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       n;
    logic       d;
    logic [2:0] ev;
    logic       ew;
    string      nm;
  } vec_t;

  typedef struct {
    logic [2:0] ev;
    logic       ew;
    string      nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests;
  int   fails;

  function automatic void add(input logic r, input logic n, input logic d,
                              input logic [2:0] ev, input logic ew, input string nm);
    vec_t v;
    v.r = r; v.n = n; v.d = d; v.ev = ev; v.ew = ew; v.nm = nm;
    vecs.push_back(v);
  endfunction

  function automatic void expect_out(input logic [2:0] ev, input logic ew, input string nm);
    exp_t e;
    e.ev = ev; e.ew = ew; e.nm = nm;
    sb.push_back(e);
  endfunction

  task automatic check_out();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: no expected entry for value=%0d", value);
    end else begin
      e = sb.pop_front();
      if (value !== e.ev) begin
        fails++;
        $display("FAIL %s: value=%0d expected %0d", e.nm, value, e.ev);
      end
`ifdef MOD7_WRAP_FLAG_EN
      if (wrap !== e.ew) begin
        fails++;
        $display("FAIL %s_wrap: wrap=%0b expected %0b", e.nm, wrap, e.ew);
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic n, input logic d,
                      input logic [2:0] ev, input logic ew, input string nm);
    @(negedge clk);
    rst = r; now = n; dir = d;
    expect_out(ev, ew, nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned mv;
  logic        mr, mn, md, mw;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; now = 1'b1; dir = 1'b1;

    // reset state while now=1
    repeat (2) @(posedge clk);
    #1;
    expect_out(3'd0, 1'b0, "reset_state");
    check_out();

    // up 9 edges, wrap after 6->0
    add(1,1,1,1,0,"up1"); add(1,1,1,2,0,"up2"); add(1,1,1,3,0,"up3");
    add(1,1,1,4,0,"up4"); add(1,1,1,5,0,"up5"); add(1,1,1,6,0,"up6");
    add(1,1,1,0,1,"up_wrap"); add(1,1,1,1,0,"up8"); add(1,1,1,2,0,"up9");
    // hold at 2 while dir toggles
    add(1,0,0,2,0,"hold1"); add(1,0,1,2,0,"hold2");
    add(1,0,0,2,0,"hold3"); add(1,0,1,2,0,"hold4");
    // reach 3, then up one, down two
    add(1,1,1,3,0,"to3"); add(1,1,1,4,0,"flip_up");
    add(1,1,0,3,0,"flip_dn1"); add(1,1,0,2,0,"flip_dn2");
    // reset then count down 8
    add(0,1,0,0,0,"rst_dn"); add(1,1,0,6,1,"dn_wrap1"); add(1,1,0,5,0,"dn5");
    add(1,1,0,4,0,"dn4"); add(1,1,0,3,0,"dn3"); add(1,1,0,2,0,"dn2");
    add(1,1,0,1,0,"dn1"); add(1,1,0,0,0,"dn0"); add(1,1,0,6,1,"dn_wrap2");
    // reset mid-run, resume from 0
    add(0,1,1,0,0,"rst_mid"); add(1,1,1,1,0,"resume");

    foreach (vecs[i]) step(vecs[i].r, vecs[i].n, vecs[i].d, vecs[i].ev, vecs[i].ew, vecs[i].nm);

    // asynchronous reset between edges
    step(0,1,1,0,0,"pre_async");
    step(1,1,1,1,0,"pre_async1");
    step(1,1,1,2,0,"pre_async2");
    #2;
    rst = 1'b0;
    #1;
    expect_out(3'd0, 1'b0, "async_rst");
    check_out();
    step(0,1,1,0,0,"rst_hold1");
    step(0,1,0,0,0,"rst_hold2");
    step(1,1,1,1,0,"first_count");

    // reset must also clear a pending wrap pulse
    step(0,1,0,0,0,"pre_wrap_rst");
    step(1,1,0,6,1,"wrap_set");
    #2;
    rst = 1'b0;
    #1;
    expect_out(3'd0, 1'b0, "wrap_async_rst");
    check_out();

    // illegal-state recovery under each input combination
    @(negedge clk);
    rst = 1'b1; now = 1'b0; dir = 1'b1;
    force dut.value = 3'd7;
    #1;
    release dut.value;
    expect_out(3'd0, 1'b0, "illegal_hold");
    @(posedge clk); #1; check_out();

    @(negedge clk);
    now = 1'b1; dir = 1'b1;
    force dut.value = 3'd7;
    #1;
    release dut.value;
    expect_out(3'd0, 1'b0, "illegal_up");
    @(posedge clk); #1; check_out();

    @(negedge clk);
    now = 1'b1; dir = 1'b0;
    force dut.value = 3'd7;
    #1;
    release dut.value;
    expect_out(3'd0, 1'b0, "illegal_dn");
    @(posedge clk); #1; check_out();

    // randomized run against a modulo model
    step(0,0,0,0,0,"rand_rst");
    mv = 0;
    for (int k = 0; k < 60; k++) begin
      mr = ($urandom_range(0, 15) != 0);
      mn = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      mw = 1'b0;
      if (!mr) begin
        mv = 0;
      end else if (mn) begin
        mw = (md && mv == 6) || (!md && mv == 0);
        mv = md ? (mv + 1) % 7 : (mv + 6) % 7;
      end
      step(mr, mn, md, 3'(mv), mw, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
